convert_to_capital_or_small: RTL and testbench

- Registered ASCII case converter for an 8-bit character stream.
- Each valid character is classified:
  - Upper-case letters are converted to lower case.
  - Lower-case letters are converted to upper case.
  - All other codes pass unchanged.
- A flag reports whether the input was a capital letter.
- Sits in the character datapath between a byte source (UART/parser) and downstream text consumers.

---
 rtl/ascii_pkg.sv | 23 ++
 rtl/convert_to_capital_or_small_if.sv | 36 +++
 rtl/convert_to_capital_or_small_classifier.sv | 29 ++
 rtl/convert_to_capital_or_small.sv | 103 ++++++++++
 tb/tb_convert_to_capital_or_small.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ascii_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ascii_pkg
// Brief    : ASCII letter range constants and the character class enum shared
//            by the case converter and its classifier.
// Revision : 1.0 - initial release
// ============================================================================
package ascii_pkg;

    localparam logic [7:0] ASCII_UPPER_FIRST = 8'h41;
    localparam logic [7:0] ASCII_UPPER_LAST  = 8'h5A;
    localparam logic [7:0] ASCII_LOWER_FIRST = 8'h61;
    localparam logic [7:0] ASCII_LOWER_LAST  = 8'h7A;
    localparam logic [7:0] ASCII_CASE_BIT    = 8'h20;

    typedef enum logic [1:0] {
        CLS_OTHER = 2'd0,
        CLS_UPPER = 2'd1,
        CLS_LOWER = 2'd2
    } char_class_t;

endpackage : ascii_pkg
`default_nettype wire

// File: rtl/convert_to_capital_or_small_if.sv
`default_nettype none
// ============================================================================
// Module   : convert_to_capital_or_small_if
// Brief    : Character stream bundle: source-side valid/byte in, converted
//            byte plus classification flags out.
// Revision : 1.0 - initial release
// ============================================================================
interface convert_to_capital_or_small_if;

    logic       in_valid;
    logic [7:0] in;
    logic       out_valid;
    logic [7:0] out;
    logic       cap;
    logic       is_alpha;

    modport master (
        output in_valid,
        output in,
        input  out_valid,
        input  out,
        input  cap,
        input  is_alpha
    );

    modport slave (
        input  in_valid,
        input  in,
        output out_valid,
        output out,
        output cap,
        output is_alpha
    );

endinterface : convert_to_capital_or_small_if
`default_nettype wire

// File: rtl/convert_to_capital_or_small_classifier.sv
`default_nettype none
// ============================================================================
// Module   : ascii_case_classifier
// Brief    : Combinational ASCII classifier producing the character class and
//            the case-swapped byte (non-letters pass through unchanged).
// Revision : 1.0 - initial release
// ============================================================================
module ascii_case_classifier
    import ascii_pkg::*;
(
    input  wire logic [7:0] ch,
    output char_class_t     cls,
    output logic [7:0]      swapped
);

    always_comb begin
        cls = CLS_OTHER;
        if ((ch >= ASCII_UPPER_FIRST) && (ch <= ASCII_UPPER_LAST)) begin
            cls = CLS_UPPER;
        end else if ((ch >= ASCII_LOWER_FIRST) && (ch <= ASCII_LOWER_LAST)) begin
            cls = CLS_LOWER;
        end
    end

    // Letters differ between cases only in bit 5.
    assign swapped = (cls != CLS_OTHER) ? (ch ^ ASCII_CASE_BIT) : ch;

endmodule : ascii_case_classifier
`default_nettype wire

// File: rtl/convert_to_capital_or_small.sv
`default_nettype none
// ============================================================================
// Module   : convert_to_capital_or_small
// Brief    : Registered ASCII case swapper, one-cycle latency, always ready.
//            Define CASE_STATS_EN to add upper/lower letter counters.
// Revision : 1.0 - initial release
// ============================================================================
module convert_to_capital_or_small
    import ascii_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    convert_to_capital_or_small_if.slave bus
`ifdef CASE_STATS_EN
    ,
    output logic [CNT_W-1:0]            upper_cnt,
    output logic [CNT_W-1:0]            lower_cnt
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    char_class_t w_cls;
    logic [7:0]  w_swapped;

    ascii_case_classifier u_classifier (
        .ch      (bus.in),
        .cls     (w_cls),
        .swapped (w_swapped)
    );

    logic [7:0] out_q, out_d;
    logic       cap_q, cap_d;
    logic       is_alpha_q, is_alpha_d;
    logic       out_valid_q, out_valid_d;

    always_comb begin
        out_d       = out_q;
        cap_d       = cap_q;
        is_alpha_d  = is_alpha_q;
        out_valid_d = bus.in_valid;
        if (bus.in_valid) begin
            out_d      = w_swapped;
            cap_d      = (w_cls == CLS_UPPER);
            is_alpha_d = (w_cls != CLS_OTHER);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= 8'h00;
            cap_q       <= 1'b0;
            is_alpha_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            cap_q       <= cap_d;
            is_alpha_q  <= is_alpha_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.cap       = cap_q;
    assign bus.is_alpha  = is_alpha_q;
    assign bus.out_valid = out_valid_q;

`ifdef CASE_STATS_EN
    logic [CNT_W-1:0] upper_cnt_q, upper_cnt_d;
    logic [CNT_W-1:0] lower_cnt_q, lower_cnt_d;

    // Counters wrap freely; no saturation.
    always_comb begin
        upper_cnt_d = upper_cnt_q;
        lower_cnt_d = lower_cnt_q;
        if (bus.in_valid && (w_cls == CLS_UPPER)) begin
            upper_cnt_d = upper_cnt_q + 1'b1;
        end
        if (bus.in_valid && (w_cls == CLS_LOWER)) begin
            lower_cnt_d = lower_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upper_cnt_q <= '0;
            lower_cnt_q <= '0;
        end else begin
            upper_cnt_q <= upper_cnt_d;
            lower_cnt_q <= lower_cnt_d;
        end
    end

    assign upper_cnt = upper_cnt_q;
    assign lower_cnt = lower_cnt_q;
`endif

endmodule : convert_to_capital_or_small
`default_nettype wire

// File: tb/tb_convert_to_capital_or_small.sv
`default_nettype none
// ============================================================================
// Module   : tb_convert_to_capital_or_small
// Brief    : Self-checking bench: directed cases plus random stream compared
//            every cycle against a behavioural case-swap model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_convert_to_capital_or_small;

    localparam int CNT_W = 16;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    convert_to_capital_or_small_if bus_if ();

`ifdef CASE_STATS_EN
    logic [CNT_W-1:0] upper_cnt;
    logic [CNT_W-1:0] lower_cnt;
`endif

    convert_to_capital_or_small #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
`ifdef CASE_STATS_EN
        ,
        .upper_cnt (upper_cnt),
        .lower_cnt (lower_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: letters move by 32 code points between cases.
    function automatic logic [7:0] ref_conv(input logic [7:0] c);
        int v;
        v = int'(c);
        if (v >= 65 && v <= 90)  return 8'(v + 32);
        if (v >= 97 && v <= 122) return 8'(v - 32);
        return c;
    endfunction

    function automatic bit ref_is_upper(input logic [7:0] c);
        return (int'(c) >= 65) && (int'(c) <= 90);
    endfunction

    function automatic bit ref_is_lower(input logic [7:0] c);
        return (int'(c) >= 97) && (int'(c) <= 122);
    endfunction

    logic [7:0]       m_out;
    logic             m_cap;
    logic             m_alpha;
    logic             m_valid;
    logic [CNT_W-1:0] m_upper;
    logic [CNT_W-1:0] m_lower;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out   <= 8'h00;
            m_cap   <= 1'b0;
            m_alpha <= 1'b0;
            m_valid <= 1'b0;
            m_upper <= '0;
            m_lower <= '0;
        end else begin
            m_valid <= bus_if.in_valid;
            if (bus_if.in_valid) begin
                m_out   <= ref_conv(bus_if.in);
                m_cap   <= ref_is_upper(bus_if.in);
                m_alpha <= ref_is_upper(bus_if.in) || ref_is_lower(bus_if.in);
                if (ref_is_upper(bus_if.in)) m_upper <= m_upper + 1'b1;
                if (ref_is_lower(bus_if.in)) m_lower <= m_lower + 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    bit cmp_en;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model.out_valid", 32'(bus_if.out_valid), 32'(m_valid));
            check("model.out",       32'(bus_if.out),       32'(m_out));
            check("model.cap",       32'(bus_if.cap),       32'(m_cap));
            check("model.is_alpha",  32'(bus_if.is_alpha),  32'(m_alpha));
`ifdef CASE_STATS_EN
            check("model.upper_cnt", 32'(upper_cnt), 32'(m_upper));
            check("model.lower_cnt", 32'(lower_cnt), 32'(m_lower));
`endif
        end
    end

    task automatic send(input logic [7:0] c, input logic v);
        @(negedge clk);
        bus_if.in_valid = v;
        bus_if.in       = c;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [7:0] o, input logic c, input logic a, input logic v);
        check({name, ".out"},       32'(bus_if.out),       32'(o));
        check({name, ".cap"},       32'(bus_if.cap),       32'(c));
        check({name, ".is_alpha"},  32'(bus_if.is_alpha),  32'(a));
        check({name, ".out_valid"}, 32'(bus_if.out_valid), 32'(v));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] upper_seq [4] = '{8'h41, 8'h4A, 8'h52, 8'h5A};
    logic [7:0] lower_seq [3] = '{8'h64, 8'h76, 8'h77};
    logic [7:0] bound_seq [8] = '{8'h40, 8'h5B, 8'h60, 8'h7B, 8'h30, 8'hC1, 8'h00, 8'h7F};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        cmp_en = 1'b0;
        rst_n  = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.in       = 8'h41;

        repeat (3) @(posedge clk);
        #1;
        expect_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        cmp_en = 1'b1;

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_out("first_after_reset", 8'h61, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 4; i++) begin
            send(upper_seq[i], 1'b1);
            expect_out("upper", upper_seq[i] + 8'h20, 1'b1, 1'b1, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            send(lower_seq[i], 1'b1);
            expect_out("lower", lower_seq[i] - 8'h20, 1'b0, 1'b1, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            send(bound_seq[i], 1'b1);
            expect_out("boundary", bound_seq[i], 1'b0, 1'b0, 1'b1);
        end
        send(8'h7A, 1'b1);
        expect_out("z_lower_edge", 8'h5A, 1'b0, 1'b1, 1'b1);

        send(8'h41, 1'b1);
        send(8'h62, 1'b0);
        expect_out("valid_gap", 8'h61, 1'b1, 1'b1, 1'b0);

        // Asynchronous clear between edges, then a character held under reset.
        send(8'h5A, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        expect_out("dropped_in_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        rst_n = 1'b1;

`ifdef CASE_STATS_EN
        send(8'h41, 1'b1);
        send(8'h4A, 1'b1);
        send(8'h64, 1'b1);
        send(8'h40, 1'b1);
        send(8'h5A, 1'b1);
        check("stats.upper_cnt", 32'(upper_cnt), 32'd3);
        check("stats.lower_cnt", 32'(lower_cnt), 32'd1);
        pulse_reset();
`endif

        for (int n = 0; n < 2000; n++) begin
            logic [7:0] c;
            case ($urandom_range(0, 3))
                0:       c = 8'($urandom_range(0, 255));
                1:       c = 8'($urandom_range(8'h41, 8'h5A));
                2:       c = 8'($urandom_range(8'h61, 8'h7A));
                default: c = 8'($urandom_range(8'h3E, 8'h7D));
            endcase
            send(c, ($urandom_range(0, 3) != 0));
            if (n == 1000) pulse_reset();
        end

        @(negedge clk);
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_convert_to_capital_or_small
`default_nettype wire
